// File: rtl/dsp19x2_mac_sequencer_if.sv
// Operand stream and result stream for the DSP19X2 MAC sequencer.
// master = sample source / result sink, slave = sequencer.
interface dsp19x2_mac_sequencer_if;
    logic        s_valid;
    logic        s_ready;
    logic [9:0]  s_a1;
    logic [9:0]  s_a2;
    logic [8:0]  s_b1;
    logic [8:0]  s_b2;
    logic        cfg_unsigned_a;
    logic        cfg_unsigned_b;
    logic        cfg_subtract;
    logic        cfg_round;
    logic        cfg_saturate;
    logic [4:0]  cfg_shift_right;
    logic        m_valid;
    logic        m_ready;
    logic [18:0] m_z1;
    logic [18:0] m_z2;

    modport master (
        output s_valid, s_a1, s_a2, s_b1, s_b2,
        output cfg_unsigned_a, cfg_unsigned_b, cfg_subtract,
        output cfg_round, cfg_saturate, cfg_shift_right,
        output m_ready,
        input  s_ready, m_valid, m_z1, m_z2
    );

    modport slave (
        input  s_valid, s_a1, s_a2, s_b1, s_b2,
        input  cfg_unsigned_a, cfg_unsigned_b, cfg_subtract,
        input  cfg_round, cfg_saturate, cfg_shift_right,
        input  m_ready,
        output s_ready, m_valid, m_z1, m_z2
    );
endinterface

// File: rtl/dsp19x2_mac_sequencer.sv
// Sequencer driving a DSP19X2 dual MAC: NUM_TERMS pairs -> one dot product.
// Optional `DSP19X2_SEQ_ABORT_EN adds an abort input for ACCUM/DRAIN.
module dsp19x2_mac_sequencer #(
    parameter int NUM_TERMS   = 8,
    parameter int DSP_LATENCY = 3
) (
    input  logic        CLK,
    input  logic        RESET,
    dsp19x2_mac_sequencer_if.slave bus,
`ifdef DSP19X2_SEQ_ABORT_EN
    input  logic        abort,
`endif
    output logic [9:0]  dsp_a1,
    output logic [9:0]  dsp_a2,
    output logic [8:0]  dsp_b1,
    output logic [8:0]  dsp_b2,
    output logic [2:0]  dsp_feedback,
    output logic        dsp_load_acc,
    output logic        dsp_unsigned_a,
    output logic        dsp_unsigned_b,
    output logic        dsp_subtract,
    output logic        dsp_round,
    output logic        dsp_saturate,
    output logic [4:0]  dsp_shift_right,
    output logic [4:0]  dsp_acc_fir,
    input  logic [18:0] dsp_z1,
    input  logic [18:0] dsp_z2
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ACCUM = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]  r_state;
    logic [6:0]  r_term_cnt;
    logic [2:0]  r_drain_cnt;
    logic [9:0]  r_a1;
    logic [9:0]  r_a2;
    logic [8:0]  r_b1;
    logic [8:0]  r_b2;
    logic [2:0]  r_feedback;
    logic        r_load_acc;
    logic        r_unsigned_a;
    logic        r_unsigned_b;
    logic        r_subtract;
    logic        r_round;
    logic        r_saturate;
    logic [4:0]  r_shift_right;
    logic        r_m_valid;
    logic [18:0] r_m_z1;
    logic [18:0] r_m_z2;

    logic        w_s_ready;
    logic        w_accept;
    logic        w_abort;
    logic [6:0]  w_term_nxt;

`ifdef DSP19X2_SEQ_ABORT_EN
    assign w_abort = abort;
`else
    assign w_abort = 1'b0;
`endif

    assign w_s_ready  = (r_state == S_IDLE) || (r_state == S_ACCUM);
    assign w_accept   = bus.s_valid && w_s_ready;
    assign w_term_nxt = r_term_cnt + 7'd1;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            r_state       <= S_IDLE;
            r_term_cnt    <= 7'd0;
            r_drain_cnt   <= 3'd0;
            r_a1          <= 10'd0;
            r_a2          <= 10'd0;
            r_b1          <= 9'd0;
            r_b2          <= 9'd0;
            r_feedback    <= 3'b000;
            r_load_acc    <= 1'b0;
            r_unsigned_a  <= 1'b1;
            r_unsigned_b  <= 1'b1;
            r_subtract    <= 1'b0;
            r_round       <= 1'b0;
            r_saturate    <= 1'b0;
            r_shift_right <= 5'd0;
            r_m_valid     <= 1'b0;
            r_m_z1        <= 19'd0;
            r_m_z2        <= 19'd0;
        end else begin
            // accumulator only advances on cycles that carry a term
            r_load_acc <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_unsigned_a  <= bus.cfg_unsigned_a;
                        r_unsigned_b  <= bus.cfg_unsigned_b;
                        r_subtract    <= bus.cfg_subtract;
                        r_round       <= bus.cfg_round;
                        r_saturate    <= bus.cfg_saturate;
                        r_shift_right <= bus.cfg_shift_right;
                        r_a1          <= bus.s_a1;
                        r_a2          <= bus.s_a2;
                        r_b1          <= bus.s_b1;
                        r_b2          <= bus.s_b2;
                        r_feedback    <= 3'b001;
                        r_load_acc    <= 1'b1;
                        r_term_cnt    <= 7'd1;
                        if (NUM_TERMS == 1) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= 3'(DSP_LATENCY);
                        end else begin
                            r_state <= S_ACCUM;
                        end
                    end
                end
                S_ACCUM: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (w_accept) begin
                        r_a1       <= bus.s_a1;
                        r_a2       <= bus.s_a2;
                        r_b1       <= bus.s_b1;
                        r_b2       <= bus.s_b2;
                        r_feedback <= 3'b000;
                        r_load_acc <= 1'b1;
                        r_term_cnt <= w_term_nxt;
                        if (w_term_nxt == 7'(NUM_TERMS)) begin
                            r_state     <= S_DRAIN;
                            r_drain_cnt <= 3'(DSP_LATENCY);
                        end
                    end
                end
                S_DRAIN: begin
                    if (w_abort) begin
                        r_state <= S_IDLE;
                    end else if (r_drain_cnt == 3'd0) begin
                        r_m_z1    <= dsp_z1;
                        r_m_z2    <= dsp_z2;
                        r_m_valid <= 1'b1;
                        r_state   <= S_HOLD;
                    end else begin
                        r_drain_cnt <= r_drain_cnt - 3'd1;
                    end
                end
                S_HOLD: begin
                    if (bus.m_ready) begin
                        r_m_valid <= 1'b0;
                        r_state   <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.s_ready     = w_s_ready;
    assign bus.m_valid     = r_m_valid;
    assign bus.m_z1        = r_m_z1;
    assign bus.m_z2        = r_m_z2;
    assign dsp_a1          = r_a1;
    assign dsp_a2          = r_a2;
    assign dsp_b1          = r_b1;
    assign dsp_b2          = r_b2;
    assign dsp_feedback    = r_feedback;
    assign dsp_load_acc    = r_load_acc;
    assign dsp_unsigned_a  = r_unsigned_a;
    assign dsp_unsigned_b  = r_unsigned_b;
    assign dsp_subtract    = r_subtract;
    assign dsp_round       = r_round;
    assign dsp_saturate    = r_saturate;
    assign dsp_shift_right = r_shift_right;
    assign dsp_acc_fir     = 5'd0;

endmodule

// File: tb/tb_dsp19x2_mac_sequencer.sv
// Bench for dsp19x2_mac_sequencer with a behavioural 3-stage DSP19X2 MAC.
// Expected results are hand-computed and queued; a monitor checks handshakes.
module tb_dsp19x2_mac_sequencer;
    localparam int NT  = 4;
    localparam int LAT = 3;

    logic CLK = 1'b0;
    logic RESET = 1'b1;
    always #5 CLK = ~CLK;

    dsp19x2_mac_sequencer_if bus();

`ifdef DSP19X2_SEQ_ABORT_EN
    logic abort = 1'b0;
`endif
    logic [9:0]  dsp_a1, dsp_a2;
    logic [8:0]  dsp_b1, dsp_b2;
    logic [2:0]  dsp_feedback;
    logic        dsp_load_acc, dsp_unsigned_a, dsp_unsigned_b;
    logic        dsp_subtract, dsp_round, dsp_saturate;
    logic [4:0]  dsp_shift_right, dsp_acc_fir;
    logic [18:0] dsp_z1, dsp_z2;

    dsp19x2_mac_sequencer #(.NUM_TERMS(NT), .DSP_LATENCY(LAT)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .bus(bus.slave),
`ifdef DSP19X2_SEQ_ABORT_EN
        .abort(abort),
`endif
        .dsp_a1(dsp_a1),
        .dsp_a2(dsp_a2),
        .dsp_b1(dsp_b1),
        .dsp_b2(dsp_b2),
        .dsp_feedback(dsp_feedback),
        .dsp_load_acc(dsp_load_acc),
        .dsp_unsigned_a(dsp_unsigned_a),
        .dsp_unsigned_b(dsp_unsigned_b),
        .dsp_subtract(dsp_subtract),
        .dsp_round(dsp_round),
        .dsp_saturate(dsp_saturate),
        .dsp_shift_right(dsp_shift_right),
        .dsp_acc_fir(dsp_acc_fir),
        .dsp_z1(dsp_z1),
        .dsp_z2(dsp_z2)
    );

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int last_acc = 0;

    typedef struct {
        logic [18:0] z1;
        logic [18:0] z2;
    } exp_t;
    exp_t sb[$];

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---- behavioural DSP19X2: input regs, accumulator, output regs ----
    logic [9:0]  p_a1, p_a2;
    logic [8:0]  p_b1, p_b2;
    logic [2:0]  p_fb;
    logic        p_ld, p_ua, p_ub, p_sub, p_rnd, p_sat;
    logic [4:0]  p_sh;
    longint      acc1, acc2, m1, m2;

    function automatic longint sx10(input logic [9:0] v, input logic u);
        return u ? longint'({54'd0, v}) : longint'({{54{v[9]}}, v});
    endfunction

    function automatic longint sx9(input logic [8:0] v, input logic u);
        return u ? longint'({55'd0, v}) : longint'({{55{v[8]}}, v});
    endfunction

    function automatic logic [18:0] outz(input longint a, input logic [4:0] sh,
                                         input logic rnd, input logic sat);
        longint v;
        v = a;
        if (rnd && sh != 5'd0) v = v + (longint'(1) << (sh - 5'd1));
        v = v >>> sh;
        if (sat && v > 262143) v = 262143;
        if (sat && v < -262144) v = -262144;
        return v[18:0];
    endfunction

    always_comb begin
        m1 = sx10(p_a1, p_ua) * sx9(p_b1, p_ub);
        m2 = sx10(p_a2, p_ua) * sx9(p_b2, p_ub);
    end

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            p_a1 <= '0; p_a2 <= '0; p_b1 <= '0; p_b2 <= '0;
            p_fb <= '0; p_ld <= 1'b0; p_ua <= 1'b1; p_ub <= 1'b1;
            p_sub <= 1'b0; p_rnd <= 1'b0; p_sat <= 1'b0; p_sh <= '0;
            acc1 <= 0; acc2 <= 0; dsp_z1 <= '0; dsp_z2 <= '0;
        end else begin
            p_a1 <= dsp_a1; p_a2 <= dsp_a2; p_b1 <= dsp_b1; p_b2 <= dsp_b2;
            p_fb <= dsp_feedback; p_ld <= dsp_load_acc;
            p_ua <= dsp_unsigned_a; p_ub <= dsp_unsigned_b;
            p_sub <= dsp_subtract; p_rnd <= dsp_round;
            p_sat <= dsp_saturate; p_sh <= dsp_shift_right;
            if (p_ld) begin
                acc1 <= (p_fb == 3'b001 ? 0 : acc1) + (p_sub ? -m1 : m1);
                acc2 <= (p_fb == 3'b001 ? 0 : acc2) + (p_sub ? -m2 : m2);
            end
            dsp_z1 <= outz(acc1, p_sh, p_rnd, p_sat);
            dsp_z2 <= outz(acc2, p_sh, p_rnd, p_sat);
        end
    end

    // ---- monitor: latency, hold stability, scoreboard pop ----
    logic        prev_v = 1'b0;
    logic        prev_r = 1'b0;
    logic [37:0] prev_z = '0;

    always @(negedge CLK) begin
        if (bus.m_valid) begin
            if (!prev_v) chk("latency", 64'(cyc - last_acc), 64'(LAT + 1));
            if (prev_v && !prev_r) chk("hold_z_stable", {bus.m_z1, bus.m_z2}, prev_z);
            chk("s_ready_low_hold", bus.s_ready, 1'b0);
            if (bus.m_ready) begin
                if (sb.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_result: got z1=%0d z2=%0d expected none",
                             bus.m_z1, bus.m_z2);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("z1", bus.m_z1, e.z1);
                    chk("z2", bus.m_z2, e.z2);
                end
            end
        end
        prev_v = bus.m_valid;
        prev_r = bus.m_ready;
        prev_z = {bus.m_z1, bus.m_z2};
    end

    // ---- stimulus ----
    function automatic logic [63:0] pins();
        return {7'd0, dsp_a1, dsp_a2, dsp_b1, dsp_b2, dsp_feedback, dsp_load_acc,
                dsp_unsigned_a, dsp_unsigned_b, dsp_subtract, dsp_round,
                dsp_saturate, dsp_shift_right, dsp_acc_fir};
    endfunction

    task automatic check_reset_state();
        chk("rst_pins", pins(), 64'h6000);
        chk("rst_s_ready", bus.s_ready, 1'b1);
        chk("rst_m_valid", bus.m_valid, 1'b0);
        chk("rst_m_z", {bus.m_z1, bus.m_z2}, 38'd0);
    endtask

    task automatic set_cfg(input logic ua, input logic ub, input logic sub,
                           input logic rnd, input logic sat, input logic [4:0] sh);
        bus.cfg_unsigned_a  = ua;
        bus.cfg_unsigned_b  = ub;
        bus.cfg_subtract    = sub;
        bus.cfg_round       = rnd;
        bus.cfg_saturate    = sat;
        bus.cfg_shift_right = sh;
    endtask

    task automatic send(input logic [9:0] a1, input logic [8:0] b1,
                        input logic [9:0] a2, input logic [8:0] b2, input logic first);
        int n;
        n = 0;
        bus.s_valid = 1'b1;
        bus.s_a1 = a1; bus.s_b1 = b1; bus.s_a2 = a2; bus.s_b2 = b2;
        @(negedge CLK);
        while (!bus.s_ready) begin
            n++;
            if (n > 200) begin
                total++; bad++;
                $display("FAIL send_timeout: s_ready stuck low, expected high");
                break;
            end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1;
        last_acc = cyc;
        bus.s_valid = 1'b0;
        chk("feedback", dsp_feedback, first ? 3'b001 : 3'b000);
        chk("load_acc", dsp_load_acc, 1'b1);
    endtask

    task automatic wait_done();
        int n;
        n = 0;
        while (!(bus.m_valid && bus.m_ready)) begin
            @(negedge CLK);
            n++;
            if (n > 100) begin
                total++; bad++;
                $display("FAIL result_timeout: m_valid=%0b expected 1", bus.m_valid);
                break;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic run_prod(input logic [9:0] a1 [4], input logic [8:0] b1 [4],
                            input logic [9:0] a2, input logic [8:0] b2, input int gap,
                            input logic [18:0] e1, input logic [18:0] e2);
        exp_t e;
        e.z1 = e1;
        e.z2 = e2;
        sb.push_back(e);
        for (int i = 0; i < NT; i++) begin
            send(a1[i], b1[i], a2, b2, i == 0);
            // cfg flips after the first term must have no effect
            if (i == 0) bus.cfg_subtract = ~bus.cfg_subtract;
            if (gap > 0 && i < NT - 1) begin
                for (int g = 0; g < gap; g++) begin
                    @(posedge CLK);
                    #1;
                    chk("gap_load_acc", dsp_load_acc, 1'b0);
                end
            end
        end
        bus.cfg_subtract = ~bus.cfg_subtract;
        if (bus.m_ready) wait_done();
    endtask

    logic [9:0] va1 [4];
    logic [8:0] vb1 [4];
    logic [9:0] sa1 [4];
    logic [8:0] sb1 [4];
    logic [9:0] ra1 [4];
    logic [8:0] rb1 [4];

    initial begin
        int n;
        va1 = '{10'd1, 10'd3, 10'd5, 10'd7};
        vb1 = '{9'd2, 9'd4, 9'd6, 9'd8};
        sa1 = '{10'h3FF, 10'h3FF, 10'h3FF, 10'h3FF};
        sb1 = '{9'd5, 9'd5, 9'd5, 9'd5};
        ra1 = '{10'd1, 10'd2, 10'd2, 10'd2};
        rb1 = '{9'd1, 9'd1, 9'd1, 9'd1};
        bus.s_valid = 1'b0;
        bus.s_a1 = '0; bus.s_a2 = '0; bus.s_b1 = '0; bus.s_b2 = '0;
        bus.m_ready = 1'b1;
        set_cfg(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
        #12;
        check_reset_state();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        // unsigned, back-to-back terms
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        run_prod(va1, vb1, 10'd10, 9'd1, 0, 19'd100, 19'd40);

        // signed subtract: -(-1*5)*4
        set_cfg(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
        run_prod(sa1, sb1, 10'd0, 9'd0, 0, 19'd20, 19'd0);

        // bubbles between terms
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        run_prod(va1, vb1, 10'd10, 9'd1, 3, 19'd100, 19'd40);

        // back-pressure on the result port
        bus.m_ready = 1'b0;
        run_prod(va1, vb1, 10'd10, 9'd1, 0, 19'd100, 19'd40);
        n = 0;
        while (!bus.m_valid && n < 50) begin
            @(posedge CLK);
            n++;
        end
        chk("hold_m_valid_seen", bus.m_valid, 1'b1);
        repeat (10) @(posedge CLK);
        #1;
        chk("hold_m_valid_still", bus.m_valid, 1'b1);
        bus.m_ready = 1'b1;
        @(posedge CLK);
        #1;
        chk("s_ready_after_hs", bus.s_ready, 1'b1);
        chk("m_valid_after_hs", bus.m_valid, 1'b0);

        // reset mid-product
        set_cfg(1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd3);
        send(10'd9, 9'd9, 10'd9, 9'd9, 1'b1);
        send(10'd9, 9'd9, 10'd9, 9'd9, 1'b0);
        RESET = 1'b1;
        #2;
        check_reset_state();
        @(negedge CLK);
        RESET = 1'b0;
        @(posedge CLK);
        #1;
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        run_prod(va1, vb1, 10'd10, 9'd1, 0, 19'd100, 19'd40);

        // shift/round: (7 + 2) >> 2
        set_cfg(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd2);
        run_prod(ra1, rb1, 10'd0, 9'd0, 0, 19'd2, 19'd0);

`ifdef DSP19X2_SEQ_ABORT_EN
        set_cfg(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0);
        send(10'd100, 9'd100, 10'd100, 9'd100, 1'b1);
        send(10'd100, 9'd100, 10'd100, 9'd100, 1'b0);
        abort = 1'b1;
        @(posedge CLK);
        #1;
        abort = 1'b0;
        chk("abort_load_acc", dsp_load_acc, 1'b0);
        chk("abort_s_ready", bus.s_ready, 1'b1);
        repeat (20) @(posedge CLK);
        #1;
        chk("abort_no_valid", bus.m_valid, 1'b0);
        run_prod(va1, vb1, 10'd10, 9'd1, 0, 19'd100, 19'd40);
`endif

        repeat (5) @(posedge CLK);
        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
